// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU execute unit.
// The unit owns the HI/LO pair. One operation runs as IDLE -> CALC (32 iterations)
// -> FIX (sign correction and writeback). The result is visible 34 cycles after accept.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divzero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Iteration state. a_reg holds the multiplier (it shifts right) or the dividend.
  // For a divide, a_reg shifts left and collects quotient bits at the bottom.
  // b_reg holds the multiplicand (it shifts left) or the divisor in its low word.
  // acc_reg holds the product, or the partial remainder in bits [WIDTH:0].
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [WIDTH-1:0]     a_reg, a_next;
  logic [2*WIDTH-1:0]   b_reg, b_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic                 is_div_reg, is_div_next;
  logic                 res_neg_reg, res_neg_next;
  logic                 dvd_neg_reg, dvd_neg_next;
  logic                 dz_reg, dz_next;

  // Architectural outputs
  logic [WIDTH-1:0]     hi_reg, hi_next;
  logic [WIDTH-1:0]     lo_reg, lo_next;
  logic                 divzero_reg, divzero_next;
  logic                 done_reg, done_next;

  // Combinational helpers
  logic                 accept;
  logic                 is_signed, neg1, neg2;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       rem_shift, rem_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Operand magnitudes and the one-step divide and sign-fix arithmetic
  always_comb begin
    accept    = (state_reg == IDLE) && start && !flush;
    is_signed = ~op[0];
    neg1      = is_signed & operand1[WIDTH-1];
    neg2      = is_signed & operand2[WIDTH-1];
    // The negation of 0x80000000 wraps back to 0x80000000. That value is its correct unsigned magnitude.
    mag1      = neg1 ? -operand1 : operand1;
    mag2      = neg2 ? -operand2 : operand2;
    rem_shift = {acc_reg[WIDTH-1:0], a_reg[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_reg[WIDTH-1:0]};
    prod_fix  = res_neg_reg ? -acc_reg : acc_reg;
    // For a zero divisor the remainder path already gives back operand1 unchanged.
    // Only the quotient is forced to all ones.
    quo_fix   = dz_reg ? '1 : (res_neg_reg ? -a_reg : a_reg);
    rem_fix   = dvd_neg_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. A flush aborts the operation, and it also wins over a start in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (flush) state_next = IDLE;
               else if (cnt_reg == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state register and the result registers
  always_comb begin
    busy    = (state_reg != IDLE);
    done    = done_reg;
    hi      = hi_reg;
    lo      = lo_reg;
    divzero = divzero_reg;
  end

  // Datapath next values: latch at accept, iterate in CALC, write back in FIX
  always_comb begin
    cnt_next     = cnt_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    acc_next     = acc_reg;
    is_div_next  = is_div_reg;
    res_neg_next = res_neg_reg;
    dvd_neg_next = dvd_neg_reg;
    dz_next      = dz_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    divzero_next = divzero_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          is_div_next  = op[1];
          res_neg_next = neg1 ^ neg2;
          dvd_neg_next = neg1;
          dz_next      = op[1] && (operand2 == '0);
          a_next       = op[1] ? mag1 : mag2;
          b_next       = {{WIDTH{1'b0}}, (op[1] ? mag2 : mag1)};
          acc_next     = '0;
          cnt_next     = '0;
        end
      end
      CALC: begin
        cnt_next = cnt_reg + 1'b1;
        if (is_div_reg) begin
          // Restoring step: keep the trial subtraction only when it did not borrow
          if (!rem_diff[WIDTH]) begin
            acc_next = {{(WIDTH-1){1'b0}}, rem_diff};
            a_next   = {a_reg[WIDTH-2:0], 1'b1};
          end else begin
            acc_next = {{(WIDTH-1){1'b0}}, rem_shift};
            a_next   = {a_reg[WIDTH-2:0], 1'b0};
          end
        end else begin
          // Shift-add step. The multiplier is consumed LSB first.
          if (a_reg[0]) acc_next = acc_reg + b_reg;
          b_next = {b_reg[2*WIDTH-2:0], 1'b0};
          a_next = {1'b0, a_reg[WIDTH-1:1]};
        end
      end
      FIX: begin
        if (!flush) begin
          if (is_div_reg) begin
            hi_next = rem_fix;
            lo_next = quo_fix;
          end else begin
            hi_next = prod_fix[2*WIDTH-1:WIDTH];
            lo_next = prod_fix[WIDTH-1:0];
          end
          divzero_next = dz_reg;
          done_next    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers. Reset clears everything at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg     <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      is_div_reg  <= 1'b0;
      res_neg_reg <= 1'b0;
      dvd_neg_reg <= 1'b0;
      dz_reg      <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      divzero_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      acc_reg     <= acc_next;
      is_div_reg  <= is_div_next;
      res_neg_reg <= res_neg_next;
      dvd_neg_reg <= dvd_neg_next;
      dz_reg      <= dz_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      divzero_reg <= divzero_next;
      done_reg    <= done_next;
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide execute unit for MULT, MULTU, DIV and DIVU. The ALU computes every other arithmetic op in one combinational pass. This block is the multi-cycle counterpart: the datapath issues a request with a start/busy/done handshake, and the block returns a 64-bit result into the HI/LO register pair it owns. It sits beside the ALU in the execute stage. The control unit stalls on `busy`.

## Interface
- `WIDTH`, 32, operand width. HI and LO are each `WIDTH` bits.
- `CLK` input 1: single clock. All state updates on the rising edge.
- `RST` input 1: reset, asynchronous and active-high.
- `start` input 1: request strobe. Sampled only in IDLE.
- `op` input 2: operation select. 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `operand1` input WIDTH: multiplicand or dividend. Sampled with `start`.
- `operand2` input WIDTH: multiplier or divisor. Sampled with `start`.
- `flush` input 1: synchronous abort of the in-flight operation.
- `busy` output 1: high while an operation is in flight.
- `done` output 1: one-cycle pulse when `hi`/`lo` carry the new result.
- `hi` output WIDTH: product high word, or remainder.
- `lo` output WIDTH: product low word, or quotient.
- `divzero` output 1: set with `done` when a DIV/DIVU had `operand2 == 0`.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE:**
  - If `start` is high, latch `op`.
  - For signed ops, latch the magnitudes of both operands as unsigned 32-bit values; |0x80000000| is 0x80000000.
  - Latch the result sign and the dividend sign.
  - Clear the iteration counter to 0 and go to CALC.
- **CALC:** one iteration per cycle, 32 iterations, counter 0..31. Go to FIX when the counter is 31.
  - **Multiply:** shift-add. 64-bit accumulator, LSB-first over the multiplier.
  - **Divide:** restoring. 33-bit partial remainder, MSB-first over the dividend, one quotient bit per cycle.
- **FIX:**
  - Apply the sign correction.
    - **Signed multiply:** negate the 64-bit product if the operand signs differ.
    - **Signed divide:** negate the quotient if the signs differ. Negate the remainder if the dividend was negative. Quotient truncates toward zero.
  - Register `hi`/`lo` and `divzero`, pulse `done`, return to IDLE.
- **Divide by zero** (DIV/DIVU with `operand2 == 0`):
  - Full normal latency.
  - Result: `lo` = 0xFFFFFFFF, `hi` = original `operand1` (unnegated), `divzero` = 1.
- **`divzero`:** cleared on every other completion. Holds its value between completions.
- **Overflow case:** DIV 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0. No exception is raised.
- **Output stability:** `hi`/`lo` change only at a FIX completion or at reset, and hold their values otherwise.

## Timing
- **Reset values:** state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, `divzero` 0, counter 0. Reset asserted mid-operation discards the operation immediately and no `done` is produced.
- **Latency:** if `start` is accepted in cycle 0, then `busy` is 1 in cycles 1–33 and `done` is 1 only in cycle 34. New `hi`/`lo` are visible from cycle 34. This is fixed at 34 cycles for all ops, including divide by zero.
- **`busy`:** low in the `done` cycle.
- **Handshake:**
  - `start` is ignored while `busy` is high.
  - `start` in the `done` cycle is accepted, giving back-to-back operations every 34 cycles.
  - Operands are not required to be stable after the accept cycle.
- **`flush`:**
  - In CALC or FIX, `flush` returns the block to IDLE at the next edge.
  - `busy` goes low the next cycle, no `done` is produced, and `hi`/`lo`/`divzero` are unchanged.
  - `flush` together with `start` in IDLE has `flush` winning: nothing is accepted.
  - `flush` in IDLE has no effect.

## Test plan
- **MULT:** MULT, 0xFFFFFFFD × 0x00000007 → `done` in cycle 34, `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB, `divzero` = 0.
- **MULTU:** MULTU, 0xFFFFFFFF × 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001. Follow with DIV 0x80000000 / 0xFFFFFFFF started in the `done` cycle → `done` 34 cycles later, `lo` = 0x80000000, `hi` = 0.
- **Signed divide:** DIV, 0xFFFFFFF9 (−7) / 0x00000002 → `lo` = 0xFFFFFFFD (−3), `hi` = 0xFFFFFFFF (−1). Then DIVU 0x00000064 / 0x00000007 → `lo` = 0x0000000E, `hi` = 0x00000002.
- **Divide by zero:** DIVU, 0x00000064 / 0 → `done` in cycle 34, `lo` = 0xFFFFFFFF, `hi` = 0x00000064, `divzero` = 1. The next MULT completion clears `divzero` to 0.
- **Flush:** start MULT 5 × 6 after a completed result of `hi` = 1, `lo` = 2. Assert `flush` in cycle 10 → `busy` is 0 from cycle 11, no `done` ever appears, and `hi`/`lo` stay 1/2. A `start` pulsed in cycle 5 (while busy) is ignored.
- **Reset mid-operation:** assert `RST` asynchronously mid-cycle during CALC → `busy`, `hi`, `lo` and `divzero` go to 0 without waiting for a clock edge. After release, a new MULTU 3 × 4 gives `lo` = 12 in cycle 34.
